// File: rtl/deskew_scan_ctrl.sv
// Raster scan sequencer for a skew accumulator. It walks column and row indices,
// clears and steps the accumulator, and hands addresses to a valid/ready consumer.
module deskew_scan_ctrl #(
  parameter int ROW_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_width,
  input  logic [ROW_W-1:0] cfg_height,
  output logic             acc_en,
  output logic             acc_sclr,
  output logic [7:0]       x_out,
  input  logic [23:0]      addr_in,
  output logic [23:0]      addr_out,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic             addr_last,
  output logic [ROW_W-1:0] row_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

  state_t           state, state_n;
  logic [7:0]       x_q, width_q;
  logic [ROW_W-1:0] row_q, height_q;
  logic             end_row, last_row;

  assign end_row  = (x_q == width_q);
  assign last_row = (row_q == height_q);
  assign x_out    = x_q;
  assign row_out  = row_q;
  assign addr_out = addr_in;

  always_comb begin
    state_n    = state;
    acc_en     = 1'b0;
    acc_sclr   = 1'b0;
    addr_valid = 1'b0;
    addr_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start && !abort) state_n = CLEAR;
      CLEAR: begin
        busy     = 1'b1;
        acc_sclr = 1'b1;
        state_n  = abort ? IDLE : SCAN;
      end
      SCAN: begin
        busy       = 1'b1;
        addr_valid = 1'b1;
        addr_last  = end_row && last_row;
        if (abort) begin
          acc_sclr = 1'b1;
          state_n  = IDLE;
        end else if (addr_ready) begin
          // Step the skew in the row's final transfer so the next row starts without a bubble.
          acc_en = end_row && !last_row;
          if (end_row && last_row) state_n = DONE;
        end
      end
      DONE: begin
        if (abort) acc_sclr = 1'b1;
        else       done     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_q      <= '0;
      row_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == CLEAR) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
      end
      if (state_n != SCAN) begin
        x_q   <= '0;
        row_q <= '0;
      end else if (state == SCAN && addr_ready) begin
        if (end_row) begin
          x_q   <= '0;
          row_q <= row_q + {{(ROW_W-1){1'b0}}, 1'b1};
        end else begin
          x_q <= x_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/deskew_scan_ctrl.md
DESKEW_SCAN_CTRL -- requirements
Module: deskew_scan_ctrl

Interface
REQ-001 Parameter ROW_W, default 10, width of row count and row index.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  frame start request, sampled in IDLE only.
REQ-005 abort  input  1  terminate current frame.
REQ-006 cfg_width  input  8  columns per row minus 1, captured at start.
REQ-007 cfg_height  input  ROW_W  rows per frame minus 1, captured at start.
REQ-008 acc_en  output  1  drives skew accumulator en (advance one row of skew).
REQ-009 acc_sclr  output  1  drives skew accumulator sclr.
REQ-010 x_out  output  8  column index, drives skew accumulator x_in.
REQ-011 addr_in  input  24  accumulator output (acc_out), combinational from its register and x_out.
REQ-012 addr_out  output  24  address to consumer, equal to addr_in.
REQ-013 addr_valid  output  1  addr_out valid.
REQ-014 addr_ready  input  1  consumer accepts addr_out.
REQ-015 addr_last  output  1  qualifies the final address of the frame.
REQ-016 row_out  output  ROW_W  current row index.
REQ-017 busy  output  1  high in CLEAR and SCAN.
REQ-018 done  output  1  one-cycle pulse on normal frame completion.

Function
REQ-019 FSM states IDLE, CLEAR, SCAN, DONE; a transfer is addr_valid&addr_ready.
REQ-020 IDLE: start=1 and abort=0 -> CLEAR; capture cfg_width/cfg_height; x_out=0, row_out=0.
REQ-021 CLEAR: exactly one cycle; acc_sclr=1, acc_en=0, addr_valid=0; -> SCAN.
REQ-022 SCAN: addr_valid=1 every cycle; addr_out=addr_in; throughput one address per cycle with addr_ready held high.
REQ-023 Latency: start at cycle N -> acc_sclr at N+1 -> first addr_valid at N+2.
REQ-024 Transfer with x_out<width: x_out increments next cycle; acc_en=0.
REQ-025 Transfer with x_out==width and row_out<height: x_out->0, row_out increments, and acc_en=1 in the transfer cycle, so the next address reflects the new row skew with no bubble.
REQ-026 acc_en is never asserted without a transfer; acc_en=0 on the last row.
REQ-027 addr_last=1 iff SCAN and x_out==width and row_out==height.
REQ-028 Transfer with addr_last=1 -> DONE; DONE lasts one cycle with done=1, busy=0, addr_valid=0; -> IDLE.
REQ-029 Backpressure: addr_valid=1 with addr_ready=0 holds x_out, row_out, and addr_out stable; acc_en=0.
REQ-030 abort=1 in CLEAR, SCAN or DONE -> IDLE next cycle; acc_sclr=1 in the abort cycle; acc_en=0; no done pulse; an in-flight transfer in that cycle is still taken by the consumer but does not advance counters.
REQ-031 start while busy or in DONE is ignored; start and abort together in IDLE: abort wins, stay IDLE.
REQ-032 cfg_width=0 and/or cfg_height=0 are legal; a 1x1 frame yields one address with addr_last=1.
REQ-033 Counters do not wrap past captured limits; cfg changes mid-frame have no effect.

Reset
REQ-034 rst_n=0 at a clock edge -> IDLE; x_out=0, row_out=0, acc_en=0, acc_sclr=0, addr_valid=0, addr_last=0, busy=0, done=0; captured config cleared to 0.
REQ-035 Reset mid-frame aborts with no done pulse; the first start after rst_n=1 behaves as REQ-020.

Verification (bench instantiates skew_acc with incr=0x000100, offset=0x010000)
REQ-036 cfg_width=3, cfg_height=1, addr_ready=1, start pulse -> sclr at +1; 8 addresses from +2: 0x010000, 0x010200, 0x010400, 0x010600, 0x010100, 0x010300, 0x010500, 0x010700; acc_en once on the 4th; addr_last on the 8th; done one cycle later.
REQ-037 Same frame with addr_ready=0 for 3 cycles at the 2nd address -> addr_out holds 0x010200, x_out=1, acc_en=0; the sequence then resumes unchanged.
REQ-038 cfg_width=0, cfg_height=0 -> single address 0x010000 with addr_last=1, no acc_en, done pulse.
REQ-039 abort at the 3rd address of the REQ-036 frame -> IDLE next cycle, acc_sclr=1, no done; a new start reproduces the full REQ-036 sequence.
REQ-040 start asserted during SCAN -> ignored, sequence unchanged; rst_n=0 mid-row -> all outputs 0 next cycle, no done.
